// File: rtl/data_upload_pkg.sv
// Shared command codes and FSM state encoding for the SPI upload responder.
package data_upload_pkg;

   localparam logic [7:0] CMD_UP_START = 8'h5A;
   localparam logic [7:0] CMD_UP_DATA  = 8'h5B;
   localparam logic [7:0] CMD_UP_END   = 8'h5C;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      INDEX,
      DATA,
      IGNORE
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for SCK/SS2/DI plus SCK and SS2 edge detection in clk_sys.
module spi_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sck_i,
   input  logic ss_n_i,
   input  logic di_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic ss_n_o,
   output logic ss_rise_o,
   output logic ss_fall_o,
   output logic di_o
);

   logic [2:0] sck_q;
   logic [2:0] ss_q;
   logic [1:0] di_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_q <= 3'b000;
         ss_q  <= 3'b111;
         di_q  <= 2'b00;
      end else begin
         sck_q <= {sck_q[1:0], sck_i};
         ss_q  <= {ss_q[1:0], ss_n_i};
         di_q  <= {di_q[0], di_i};
      end
   end

   // Stage 1 is the synchronised value, stage 2 its one-cycle-old copy.
   assign sck_rise_o = sck_q[1] & ~sck_q[2];
   assign sck_fall_o = ~sck_q[1] & sck_q[2];
   assign ss_n_o     = ss_q[1];
   assign ss_rise_o  = ss_q[1] & ~ss_q[2];
   assign ss_fall_o  = ~ss_q[1] & ss_q[2];
   assign di_o       = di_q[1];

endmodule

// File: rtl/data_upload.sv
// SPI upload responder: streams core memory bytes out on MISO with a one-byte prefetch.
// Optional running checksum of uploaded bytes when DATA_UPLOAD_CHKSUM_EN is defined.
//
// state  | meaning
// IDLE   | SS2 high, or command finished; waiting for SS2 to fall
// CMD    | receiving the command byte
// INDEX  | receiving the upload index after START
// DATA   | shifting prefetched bytes out on MISO
// IGNORE | discarding bytes until SS2 rises
module data_upload
   import data_upload_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int ACK_TIMEOUT = 32
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              SPI_SCK,
   input  logic              SPI_SS2,
   input  logic              SPI_DI,
   output logic              spi_do,
   output logic              spi_do_oe,
   output logic              ioctl_upload,
   output logic [7:0]        ioctl_index,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic              ioctl_rd,
   input  logic              ioctl_ack,
   input  logic [7:0]        ioctl_din,
   output logic              underrun,
   output logic [7:0]        chksum
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

   logic sck_rise, sck_fall, ss_n, ss_rise, ss_fall, di;

   spi_sync_edge u_sync (
      .clk_i      (clk_sys),
      .rst_ni     (reset_n),
      .sck_i      (SPI_SCK),
      .ss_n_i     (SPI_SS2),
      .di_i       (SPI_DI),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .ss_n_o     (ss_n),
      .ss_rise_o  (ss_rise),
      .ss_fall_o  (ss_fall),
      .di_o       (di)
   );

   state_e              state_q, state_d;
   logic [2:0]          bit_cnt_q;
   logic [6:0]          rx_sr_q;
   logic [7:0]          tx_sr_q, cur_q, buf_q, index_q;
   logic                pend_q, rd_q, upload_q, underrun_q, do_q;
   logic [TMR_W-1:0]    tmr_q;
   logic [ADDR_W-1:0]   addr_q;

   logic [7:0] rx_byte, src_byte;
   logic       byte_done, consume, fetch_new, start_cmd, end_cmd;

   assign rx_byte   = {rx_sr_q, di};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
   // A byte cut short by SS2 is replayed from cur_q instead of consuming the buffer.
   assign src_byte  = pend_q ? cur_q : buf_q;
   assign consume   = (state_q == DATA) && sck_rise && (bit_cnt_q == 3'd0);
   assign fetch_new = consume && !pend_q;
   assign start_cmd = (state_q == CMD) && byte_done && (rx_byte == CMD_UP_START);
   assign end_cmd   = (state_q == CMD) && byte_done && (rx_byte == CMD_UP_END);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ss_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  if (ss_fall) state_d = CMD;
            CMD: begin
               if (byte_done) begin
                  if (rx_byte == CMD_UP_START)                  state_d = INDEX;
                  else if (rx_byte == CMD_UP_DATA && upload_q)  state_d = DATA;
                  else if (rx_byte == CMD_UP_END)               state_d = IDLE;
                  else                                          state_d = IGNORE;
               end
            end
            INDEX: if (byte_done) state_d = IGNORE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q <= 3'd0;
         rx_sr_q   <= 7'd0;
         index_q   <= 8'd0;
      end else begin
         if (state_q == IDLE || ss_rise) begin
            bit_cnt_q <= 3'd0;
         end else if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_sr_q   <= rx_byte[6:0];
         end
         if (state_q == INDEX && byte_done) index_q <= rx_byte;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         upload_q   <= 1'b0;
         addr_q     <= '0;
         rd_q       <= 1'b0;
         tmr_q      <= '0;
         buf_q      <= 8'd0;
         underrun_q <= 1'b0;
      end else if (start_cmd) begin
         upload_q   <= 1'b1;
         addr_q     <= '0;
         underrun_q <= 1'b0;
         rd_q       <= 1'b1;
         tmr_q      <= TMR_LOAD;
      end else if (end_cmd) begin
         upload_q <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         if (rd_q) begin
            if (ioctl_ack) begin
               buf_q <= ioctl_din;
               rd_q  <= 1'b0;
            end else if (tmr_q == '0) begin
               buf_q      <= 8'hFF;
               underrun_q <= 1'b1;
               rd_q       <= 1'b0;
            end else begin
               tmr_q <= tmr_q - 1'b1;
            end
         end
         // Buffer was already sampled into the shift register this cycle, so an ack here is kept.
         if (fetch_new) begin
            addr_q <= addr_q + ADDR_W'(1);
            rd_q   <= 1'b1;
            tmr_q  <= TMR_LOAD;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tx_sr_q <= 8'd0;
         cur_q   <= 8'd0;
         pend_q  <= 1'b0;
         do_q    <= 1'b1;
      end else begin
         if (start_cmd)                          pend_q <= 1'b0;
         else if (consume)                       pend_q <= 1'b1;
         else if (state_q == DATA && byte_done)  pend_q <= 1'b0;

         if (consume) begin
            tx_sr_q <= {src_byte[6:0], 1'b0};
            cur_q   <= src_byte;
         end

         // With bit_cnt at 0 the MSB of the upcoming byte is presented before its first rising edge.
         if (state_q != DATA) begin
            do_q <= 1'b1;
         end else if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
               do_q <= src_byte[7];
            end else begin
               do_q    <= tx_sr_q[7];
               tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
         end
      end
   end

`ifdef DATA_UPLOAD_CHKSUM_EN
   logic [7:0] chksum_q;
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)       chksum_q <= 8'd0;
      else if (start_cmd) chksum_q <= 8'd0;
      else if (fetch_new) chksum_q <= chksum_q + buf_q;
   end
   assign chksum = chksum_q;
`else
   assign chksum = 8'h00;
`endif

   assign spi_do       = do_q;
   assign spi_do_oe    = (state_q == DATA) && !ss_n;
   assign ioctl_upload = upload_q;
   assign ioctl_index  = index_q;
   assign ioctl_addr   = addr_q;
   assign ioctl_rd     = rd_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_data_upload.sv
// Scoreboard bench for data_upload: expected MISO bytes queued by stimulus, popped by a SPI monitor.
module tb_data_upload;

   localparam int ADDR_W   = 3;
   localparam int SCK_HALF = 80;

   logic              clk_sys  = 1'b0;
   logic              reset_n  = 1'b0;
   logic              SPI_SCK  = 1'b0;
   logic              SPI_SS2  = 1'b1;
   logic              SPI_DI   = 1'b0;
   logic              ioctl_ack = 1'b0;
   logic [7:0]        ioctl_din = 8'h00;
   logic              spi_do, spi_do_oe, ioctl_upload, ioctl_rd, underrun;
   logic [7:0]        ioctl_index, chksum;
   logic [ADDR_W-1:0] ioctl_addr;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mem[8];
   int         ack_delay = 2;

   data_upload #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(32)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .SPI_SCK      (SPI_SCK),
      .SPI_SS2      (SPI_SS2),
      .SPI_DI       (SPI_DI),
      .spi_do       (spi_do),
      .spi_do_oe    (spi_do_oe),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_addr   (ioctl_addr),
      .ioctl_rd     (ioctl_rd),
      .ioctl_ack    (ioctl_ack),
      .ioctl_din    (ioctl_din),
      .underrun     (underrun),
      .chksum       (chksum)
   );

   always #5 clk_sys = ~clk_sys;

   // Memory model: latches the address when a request is seen, acks after ack_delay cycles.
   logic              mm_busy = 1'b0;
   int                mm_cnt  = 0;
   logic [ADDR_W-1:0] mm_addr = '0;
   always @(negedge clk_sys) begin
      ioctl_ack = 1'b0;
      if (mm_busy) begin
         if (mm_cnt == 0) begin
            ioctl_ack = 1'b1;
            ioctl_din = mem[mm_addr];
            mm_busy   = 1'b0;
         end else begin
            mm_cnt = mm_cnt - 1;
         end
      end else if (ioctl_rd) begin
         mm_busy = 1'b1;
         mm_cnt  = ack_delay - 1;
         mm_addr = ioctl_addr;
      end
   end

   // MISO monitor: master samples on SCK rising edges while the DUT drives.
   logic [7:0] mon_sr = 8'h00;
   int         mon_bits = 0;
   logic [7:0] mon_exp;
   always @(posedge SPI_SCK or posedge SPI_SS2 or negedge reset_n) begin
      if (SPI_SS2 || !reset_n) begin
         mon_bits = 0;
      end else if (spi_do_oe) begin
         mon_sr   = {mon_sr[6:0], spi_do};
         mon_bits = mon_bits + 1;
         if (mon_bits == 8) begin
            mon_bits = 0;
            checks   = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL miso_byte: got %h, no byte expected", mon_sr);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_sr !== mon_exp) begin
                  errors = errors + 1;
                  $display("FAIL miso_byte: got %h expected %h", mon_sr, mon_exp);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         SPI_DI = b[i];
         #SCK_HALF SPI_SCK = 1'b1;
         #SCK_HALF SPI_SCK = 1'b0;
      end
   endtask

   task automatic ss_low();
      @(negedge clk_sys);
      SPI_SS2 = 1'b0;
      #200;
   endtask

   task automatic ss_high();
      #200;
      SPI_SS2 = 1'b1;
      #600;
   endtask

   task automatic data_frame(input int n);
      ss_low();
      spi_bits(8'h5B, 8);
      for (int k = 0; k < n; k++) spi_bits(8'h00, 8);
      ss_high();
   endtask

   task automatic cmd_frame(input logic [7:0] c0, input logic [7:0] c1, input int n);
      ss_low();
      spi_bits(c0, 8);
      if (n > 1) spi_bits(c1, 8);
      ss_high();
   endtask

   initial begin
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;

      #33;
      check("rst_spi_do",    32'(spi_do),       32'h1);
      check("rst_oe",        32'(spi_do_oe),    32'h0);
      check("rst_upload",    32'(ioctl_upload), 32'h0);
      check("rst_index",     32'(ioctl_index),  32'h0);
      check("rst_addr",      32'(ioctl_addr),   32'h0);
      check("rst_rd",        32'(ioctl_rd),     32'h0);
      check("rst_underrun",  32'(underrun),     32'h0);
      check("rst_chksum",    32'(chksum),       32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_sys);

      cmd_frame(8'h5A, 8'h03, 2);
      check("start_index",  32'(ioctl_index),  32'h03);
      check("start_upload", 32'(ioctl_upload), 32'h1);
      check("start_addr",   32'(ioctl_addr),   32'h0);
      check("start_rd_done", 32'(ioctl_rd),    32'h0);

      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      data_frame(4);
      check("addr_after_4", 32'(ioctl_addr), 32'h4);
      check("no_underrun",  32'(underrun),   32'h0);

      ack_delay = 40;
      exp_q.push_back(8'h55);
      data_frame(1);
      check("timeout_underrun", 32'(underrun), 32'h1);
      check("timeout_rd_low",   32'(ioctl_rd), 32'h0);
      ack_delay = 2;

      exp_q.push_back(8'hFF); exp_q.push_back(8'h77);
      data_frame(2);
      check("addr_after_ff", 32'(ioctl_addr), 32'h7);

      exp_q.push_back(8'h88);
      data_frame(1);
      check("addr_wrap", 32'(ioctl_addr), 32'h0);

      exp_q.push_back(8'h11);
      ss_low();
      spi_bits(8'h5B, 8);
      spi_bits(8'h00, 8);
      spi_bits(8'h00, 3);
      ss_high();
      check("addr_partial", 32'(ioctl_addr), 32'h2);

      exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      data_frame(2);
      check("addr_resume",     32'(ioctl_addr), 32'h3);
      check("underrun_sticky", 32'(underrun),   32'h1);
`ifdef DATA_UPLOAD_CHKSUM_EN
      check("chksum_session1", 32'(chksum), 32'h63);
`else
      check("chksum_session1", 32'(chksum), 32'h00);
`endif

      cmd_frame(8'h5C, 8'h00, 1);
      check("end_upload", 32'(ioctl_upload), 32'h0);
      check("end_rd",     32'(ioctl_rd),     32'h0);

      data_frame(1);
      check("data_after_end_addr", 32'(ioctl_addr), 32'h3);

      mem[0] = 8'hF0; mem[1] = 8'h20;
      cmd_frame(8'h5A, 8'h07, 2);
      check("start2_index",    32'(ioctl_index),  32'h07);
      check("start2_upload",   32'(ioctl_upload), 32'h1);
      check("start2_underrun", 32'(underrun),     32'h0);
      check("start2_addr",     32'(ioctl_addr),   32'h0);
      check("start2_chksum",   32'(chksum),       32'h0);

      exp_q.push_back(8'hF0); exp_q.push_back(8'h20);
      data_frame(2);
      check("addr_session2", 32'(ioctl_addr), 32'h2);
`ifdef DATA_UPLOAD_CHKSUM_EN
      check("chksum_f0_20", 32'(chksum), 32'h10);
`else
      check("chksum_f0_20", 32'(chksum), 32'h00);
`endif

      ss_low();
      spi_bits(8'h5B, 8);
      spi_bits(8'h00, 4);
      reset_n = 1'b0;
      #2;
      check("mid_rst_oe",       32'(spi_do_oe),    32'h0);
      check("mid_rst_spi_do",   32'(spi_do),       32'h1);
      check("mid_rst_upload",   32'(ioctl_upload), 32'h0);
      check("mid_rst_index",    32'(ioctl_index),  32'h0);
      check("mid_rst_addr",     32'(ioctl_addr),   32'h0);
      check("mid_rst_rd",       32'(ioctl_rd),     32'h0);
      check("mid_rst_underrun", 32'(underrun),     32'h0);
      check("mid_rst_chksum",   32'(chksum),       32'h0);
      #40;
      SPI_SS2 = 1'b1;
      #40;
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
